// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit and receive sides:
//   - FSM state encoding for the serializer / deserializer
//   - default clock cycles per bit (50 MHz system clock, 115200 baud)
//   - frame data width
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int FRAME_BITS           = 8;

endpackage

// File: rtl/uart_tx_fifo_byte_fifo.sv
// byte_fifo
// Synchronous byte FIFO of 2^DEPTH_LOG2 entries. Writes into a full FIFO and
// reads from an empty FIFO are ignored. The head entry is presented
// combinationally on rd_data whenever the FIFO is not empty.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset (pointers and count to 0)
//   wr_en    in   write strobe
//   wr_data  in   byte to store
//   rd_en    in   pop strobe
//   rd_data  out  head of FIFO
//   count    out  number of bytes held (0 .. 2^DEPTH_LOG2)
//   full     out  count == 2^DEPTH_LOG2
//   empty    out  count == 0
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [FRAME_BITS-1:0] wr_data,
    input  logic                  rd_en,
    output logic [FRAME_BITS-1:0] rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [FRAME_BITS-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  wr_ok;
    logic                  rd_ok;

    // Fullness comes from the registered count, so a pop in the same cycle
    // never frees a slot for a concurrent write.
    assign full    = (count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en & ~full;
    assign rd_ok   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// UART transmitter with input FIFO. Bytes written by the core are queued and
// sent as 8N1 frames, LSB first, at CLKS_PER_BIT clocks per bit. The core
// cannot be stalled, so writes into a full FIFO are dropped and recorded in
// the sticky overflow flag (cleared only by reset).
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset; aborts any frame in flight
//   wr_data   in   byte from core
//   wrreq     in   write strobe, one byte per high cycle
//   tx        out  serial line, idle high, registered
//   busy      out  frame in progress or FIFO non-empty
//   count     out  bytes held in FIFO
//   overflow  out  sticky dropped-write flag
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | line high; pops head into shift register when FIFO non-empty
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | 8 data bits, shift[0] on the line, shift right after each bit
// STOP  | stop bit (high) for CLKS_PER_BIT cycles, then back to IDLE
//
// tx is registered from the current state, so the line lags the state by
// one clock. A byte written at edge E0 is popped at E1 and the start bit
// appears on the line after E2.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FRAME_BITS-1:0] wr_data,
    input  logic                  wrreq,
    output logic                  tx,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam int                IDX_W     = $clog2(FRAME_BITS);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRAME_BITS - 1);

    uart_state_e           state;
    logic [BAUD_W-1:0]     baud_cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [FRAME_BITS-1:0] shift_reg;
    logic                  tx_q;

    logic                  fifo_pop;
    logic [FRAME_BITS-1:0] fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;

    assign fifo_pop = (state == IDLE) & ~fifo_empty;

    byte_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wrreq),
        .wr_data(wr_data),
        .rd_en  (fifo_pop),
        .rd_data(fifo_head),
        .count  (count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx_q      <= 1'b1;
            overflow  <= 1'b0;
        end else begin
            if (wrreq && fifo_full) begin
                overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty) begin
                        shift_reg <= fifo_head;
                        baud_cnt  <= '0;
                        state     <= START;
                    end
                end

                START: begin
                    tx_q <= 1'b0;
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    tx_q <= shift_reg[0];
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt  <= '0;
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx == IDX_LAST) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    tx_q <= 1'b1;
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    tx_q  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = (state != IDLE) | (count != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// Bench for uart_tx_fifo with CLKS_PER_BIT=4, DEPTH_LOG2=2. Inputs change on
// the falling edge; outputs are sampled on the falling edge. A line monitor
// decodes every frame and compares it against the expected-byte queue that
// the stimulus fills.
module tb_uart_tx_fifo;

    localparam int N  = 4;
    localparam int DL = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    wr_data;
    logic          wrreq;
    logic          tx;
    logic          busy;
    logic [DL:0]   count;
    logic          overflow;

    int            checks = 0;
    int            fails  = 0;
    int            cyc    = 0;
    int            frames_done = 0;
    logic [7:0]    exp_q[$];
    int            fall_cyc[$];

    uart_tx_fifo #(
        .CLKS_PER_BIT(N),
        .DEPTH_LOG2  (DL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_data (wr_data),
        .wrreq   (wrreq),
        .tx      (tx),
        .busy    (busy),
        .count   (count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line monitor: fall seen at position 0, bit k sampled mid-bit at k*N + N/2.
    logic       mon_active = 1'b0;
    int         mon_pos    = 0;
    logic [9:0] mon_bits;

    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_pos    = 0;
                fall_cyc.push_back(cyc);
            end
        end else begin
            mon_pos++;
            if (mon_pos % N == N / 2) begin
                mon_bits[mon_pos / N] = tx;
            end
            if (mon_pos == 9 * N + N / 2) begin
                mon_active = 1'b0;
                check("start_bit", 32'(mon_bits[0]), 32'd0);
                check("stop_bit", 32'(mon_bits[9]), 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'(mon_bits[8:1]), 32'hFFFF_FFFF);
                end else begin
                    check("frame_data", 32'(mon_bits[8:1]), 32'(exp_q.pop_front()));
                end
                frames_done++;
            end
        end
    end

    task automatic wait_frames(input int target);
        int t = 0;
        while (frames_done < target && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("frames_done", 32'(frames_done), 32'(target));
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        wrreq = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    typedef struct {
        logic        wrreq;
        logic [7:0]  data;
        logic        push;
        logic [DL:0] exp_count;
        logic        exp_ovf;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   frames_before;
        int   falls_before;

        vecs[0] = '{1'b1, 8'h01, 1'b1, 3'd1, 1'b0};
        vecs[1] = '{1'b1, 8'h02, 1'b1, 3'd1, 1'b0};
        vecs[2] = '{1'b1, 8'h03, 1'b1, 3'd2, 1'b0};
        vecs[3] = '{1'b1, 8'h04, 1'b1, 3'd3, 1'b0};
        vecs[4] = '{1'b1, 8'h05, 1'b1, 3'd4, 1'b0};
        vecs[5] = '{1'b1, 8'h06, 1'b0, 3'd4, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b1};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b1};

        rst     = 1'b1;
        wrreq   = 1'b0;
        wr_data = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_count", 32'(count), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte 0xA5: start bit after E2, busy low by fall+41
        wrreq   = 1'b1;
        wr_data = 8'hA5;
        exp_q.push_back(8'hA5);
        @(negedge clk);                       // after E0
        wrreq = 1'b0;
        check("single_count_after_write", 32'(count), 32'd1);
        check("single_busy_after_write", 32'(busy), 32'd1);
        check("single_tx_after_e0", 32'(tx), 32'd1);
        @(negedge clk);                       // after E1
        check("single_tx_after_e1", 32'(tx), 32'd1);
        check("single_count_after_pop", 32'(count), 32'd0);
        @(negedge clk);                       // after E2
        check("single_tx_fall_e2", 32'(tx), 32'd0);
        repeat (37) @(negedge clk);
        check("single_busy_in_frame", 32'(busy), 32'd1);
        repeat (4) @(negedge clk);
        check("single_busy_after_frame", 32'(busy), 32'd0);
        wait_frames(1);
        check("single_tx_idle", 32'(tx), 32'd1);
        repeat (5) @(negedge clk);

        // Back-to-back 0x00, 0xFF
        fall_cyc.delete();
        wrreq   = 1'b1;
        wr_data = 8'h00;
        exp_q.push_back(8'h00);
        @(negedge clk);
        wr_data = 8'hFF;
        exp_q.push_back(8'hFF);
        @(negedge clk);
        wrreq = 1'b0;
        wait_frames(3);
        check("b2b_fall_count", 32'(fall_cyc.size()), 32'd2);
        if (fall_cyc.size() >= 2) begin
            check("b2b_start_spacing", 32'(fall_cyc[1] - fall_cyc[0]), 32'(10 * N + 1));
        end
        repeat (5) @(negedge clk);

        // Overflow: six writes while idle, sixth dropped
        for (int i = 0; i < 8; i++) begin
            wrreq   = vecs[i].wrreq;
            wr_data = vecs[i].data;
            if (vecs[i].push) exp_q.push_back(vecs[i].data);
            @(negedge clk);
            check($sformatf("ovf_count[%0d]", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("ovf_flag[%0d]", i), 32'(overflow), 32'(vecs[i].exp_ovf));
        end
        wrreq = 1'b0;
        wait_frames(8);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_queue_drained", 32'(exp_q.size()), 32'd0);
        do_reset();
        check("ovf_cleared_by_reset", 32'(overflow), 32'd0);

        // Full FIFO with IDLE popping and a same-cycle write
        for (int i = 0; i < 5; i++) begin
            wrreq   = 1'b1;
            wr_data = 8'(8'h11 + i);
            exp_q.push_back(8'(8'h11 + i));
            @(negedge clk);
        end
        wrreq = 1'b0;                         // now after E4
        check("simul_full_count", 32'(count), 32'd4);
        repeat (37) @(negedge clk);           // after E41, state IDLE next edge
        check("simul_pre_count", 32'(count), 32'd4);
        check("simul_pre_overflow", 32'(overflow), 32'd0);
        wrreq   = 1'b1;
        wr_data = 8'h99;
        @(negedge clk);                       // after E42
        wrreq = 1'b0;
        check("simul_count_dec", 32'(count), 32'd3);
        check("simul_overflow", 32'(overflow), 32'd1);
        wait_frames(13);
        check("simul_queue_drained", 32'(exp_q.size()), 32'd0);
        do_reset();
        repeat (2) @(negedge clk);

        // Mid-frame reset during data bit 3 of 0x3C
        wrreq   = 1'b1;
        wr_data = 8'h3C;
        exp_q.push_back(8'h3C);
        @(negedge clk);
        wr_data = 8'h77;
        exp_q.push_back(8'h77);
        @(negedge clk);
        wr_data = 8'h88;
        exp_q.push_back(8'h88);
        @(negedge clk);                       // after E2: start bit on line
        wrreq = 1'b0;
        check("midrst_queued", 32'(count), 32'd2);
        check("midrst_fall", 32'(tx), 32'd0);
        repeat (N * 4 + 1) @(negedge clk);    // inside data bit 3 (0x3C bit 3 = 1)
        check("midrst_bit3", 32'(tx), 32'd1);
        wrreq   = 1'b1;                       // ignored: reset cycle
        wr_data = 8'h55;
        rst     = 1'b1;
        exp_q.delete();
        frames_before = frames_done;
        @(negedge clk);
        check("midrst_tx_high", 32'(tx), 32'd1);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        wrreq = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        falls_before = fall_cyc.size();
        repeat (120) @(negedge clk);
        check("midrst_no_frames", 32'(frames_done), 32'(frames_before));
        check("midrst_no_falls", 32'(fall_cyc.size()), 32'(falls_before));
        check("midrst_count_after", 32'(count), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
